// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: word width, PC step, NOP encoding and
// the fetch-buffer entry layout.
package mips_pkg;

    localparam int              WORD_W    = 32;
    localparam logic [31:0]     NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0]     PC_STEP   = 32'd4;

    typedef struct packed {
        logic [WORD_W-1:0] instr;
        logic [WORD_W-1:0] pcPlus4;
    } fetch_entry_t;

    function automatic logic [WORD_W-1:0] nextPc(input logic [WORD_W-1:0] pc);
        return pc + PC_STEP;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: instruction-memory handshake toward memory plus the
// IF/ID side (redirect, stall and the presented instruction).
interface fetch_unit_if;
    import mips_pkg::*;

    logic              imem_req;
    logic [WORD_W-1:0] imem_addr;
    logic              imem_ack;
    logic              imem_rvalid;
    logic [WORD_W-1:0] imem_rdata;
    logic              redirect;
    logic [WORD_W-1:0] redirect_pc;
    logic              stall;
    logic              if_valid;
    logic [WORD_W-1:0] if_instr;
    logic [WORD_W-1:0] if_pc_plus4;

    modport master (
        output imem_req, imem_addr, if_valid, if_instr, if_pc_plus4,
        input  imem_ack, imem_rvalid, imem_rdata, redirect, redirect_pc, stall
    );

    modport slave (
        input  imem_req, imem_addr, if_valid, if_instr, if_pc_plus4,
        output imem_ack, imem_rvalid, imem_rdata, redirect, redirect_pc, stall
    );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with a flush that takes priority over push and pop.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo #(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 64,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic [CW-1:0]    o_count,
    output logic             o_empty,
    output logic             o_full
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wrPtr;
    logic [AW-1:0]    r_rdPtr;
    logic [CW-1:0]    r_count;
    logic             w_doPush;
    logic             w_doPop;

    assign w_doPush = i_push & ~i_flush;
    assign w_doPop  = i_pop & ~o_empty & ~i_flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) r_wrPtr <= r_wrPtr + AW'(1);
            if (w_doPop)  r_rdPtr <= r_rdPtr + AW'(1);
            r_count <= r_count + CW'(w_doPush) - CW'(w_doPop);
        end
    end

    // Storage needs no reset: the head is only observed when the FIFO is non-empty.
    always_ff @(posedge clk) begin
        if (w_doPush) r_mem[r_wrPtr] <= i_data;
    end

    assign o_data  = r_mem[r_rdPtr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));

endmodule

// File: rtl/fetch_unit.sv
// MIPS instruction fetch stage: owns the PC, issues credit-limited word
// fetches, drops responses made stale by a redirect and buffers the rest.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [WORD_W-1:0] r_pc;
    logic [WORD_W-1:0] r_respPc;
    logic [CW-1:0]     r_outstanding;
    logic [CW-1:0]     r_discard;

    logic [CW-1:0]     w_count;
    logic              w_empty;
    logic              w_full;
    logic              w_pop;
    logic              w_push;
    logic              w_req;
    logic              w_accept;
    logic [CW:0]       w_inUse;
    fetch_entry_t      w_newEntry;
    fetch_entry_t      w_head;

    assign w_pop    = ~w_empty & ~bus.stall & ~bus.redirect;
    assign w_push   = bus.imem_rvalid & (r_discard == '0) & ~bus.redirect;

    // Buffered plus in-flight entries, crediting the slot freed by this cycle's pop.
    assign w_inUse  = {1'b0, w_count} + {1'b0, r_outstanding} - {{CW{1'b0}}, w_pop};
    assign w_req    = ~rst & ~bus.redirect & (w_inUse < (CW+1)'(DEPTH));
    assign w_accept = w_req & bus.imem_ack;

    assign w_newEntry = '{instr: bus.imem_rdata, pcPlus4: nextPc(r_respPc)};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc     <= RESET_PC;
            r_respPc <= RESET_PC;
        end else if (bus.redirect) begin
            r_pc     <= bus.redirect_pc;
            r_respPc <= bus.redirect_pc;
        end else begin
            if (w_accept) r_pc     <= nextPc(r_pc);
            if (w_push)   r_respPc <= nextPc(r_respPc);
        end
    end

    // Responses still owed for pre-redirect fetches are counted down and dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_outstanding <= '0;
            r_discard     <= '0;
        end else begin
            r_outstanding <= r_outstanding + CW'(w_accept) - CW'(bus.imem_rvalid);
            if (bus.redirect)
                r_discard <= r_outstanding - CW'(bus.imem_rvalid);
            else if (bus.imem_rvalid && (r_discard != '0))
                r_discard <= r_discard - CW'(1);
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (bus.redirect),
        .i_push  (w_push),
        .i_data  (w_newEntry),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_count (w_count),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    assert property (@(posedge clk) disable iff (rst) !(w_push && w_full));

    assign bus.imem_req    = w_req;
    assign bus.imem_addr   = r_pc;
    assign bus.if_valid    = ~w_empty;
    assign bus.if_instr    = w_empty ? NOP_INSTR : w_head.instr;
    assign bus.if_pc_plus4 = w_empty ? '0 : w_head.pcPlus4;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: an in-order memory with random ack and
// latency, and an epoch-tagged queue model of what IF/ID should see.
module tb_fetch_unit;
    import mips_pkg::*;

    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fetch_unit_if bus();

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          ready;
    } memreq_t;

    memreq_t     memQ[$];
    logic [31:0] bufQ[$];
    int          epoch = 0;
    int          cyc = 0;
    logic [31:0] fetchPc = 32'h0;

    int nChecks = 0;
    int nPass = 0;

    int          ackPct = 0;
    int          rvPct = 0;
    int          stallPct = 0;
    int          redirPct = 0;
    int          maxLat = 1;
    int          ackHoldOff = 0;
    bit          forceStall = 0;
    bit          forceRedir = 0;
    bit          prevRedir = 0;
    logic [31:0] redirTarget = 32'h0;

    logic        sReq, sValid, sAccept;
    logic [31:0] sAddr, sInstr, sPc4;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic bit chance(input int pct);
        return int'($urandom_range(99)) < pct;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual === expected) nPass++;
        else $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, actual, expected, cyc);
    endtask

    // Drives memory responses from the in-order request queue and the IF/ID controls.
    task automatic applyStimulus();
        bit rv;
        bus.imem_ack = (ackHoldOff > 0) ? 1'b0 : chance(ackPct);
        if (ackHoldOff > 0) ackHoldOff--;
        rv = (memQ.size() > 0) && (memQ[0].ready <= cyc) && chance(rvPct);
        bus.imem_rvalid = rv;
        bus.imem_rdata  = rv ? memWord(memQ[0].addr) : $urandom();
        bus.stall       = forceStall || chance(stallPct);
        if (forceRedir) begin
            bus.redirect    = 1'b1;
            bus.redirect_pc = redirTarget;
            forceRedir      = 0;
        end else if (!prevRedir && chance(redirPct)) begin
            bus.redirect    = 1'b1;
            bus.redirect_pc = $urandom() & 32'hFFFF_FFFC;
        end else begin
            bus.redirect    = 1'b0;
            bus.redirect_pc = $urandom();
        end
        prevRedir = bus.redirect;
    endtask

    // One cycle: drive, compare against the model, then advance the model to the next edge.
    task automatic stepCycle();
        bit      expValid, pop, expReq, deliver;
        memreq_t r;
        @(negedge clk);
        rst = 1'b0;
        applyStimulus();
        #1;
        expValid = bufQ.size() != 0;
        pop      = expValid && !bus.stall && !bus.redirect;
        expReq   = !bus.redirect && ((bufQ.size() + memQ.size() - (pop ? 1 : 0)) < DEPTH);

        checkOutput("if_valid", 32'(bus.if_valid), 32'(expValid));
        checkOutput("imem_req", 32'(bus.imem_req), 32'(expReq));
        if (expValid) begin
            checkOutput("if_instr", bus.if_instr, memWord(bufQ[0]));
            checkOutput("if_pc_plus4", bus.if_pc_plus4, bufQ[0] + 32'd4);
        end else begin
            checkOutput("if_instr_idle", bus.if_instr, NOP_INSTR);
            checkOutput("if_pc_plus4_idle", bus.if_pc_plus4, 32'h0);
        end
        if (expReq) checkOutput("imem_addr", bus.imem_addr, fetchPc);

        sReq    = bus.imem_req;
        sAddr   = bus.imem_addr;
        sValid  = bus.if_valid;
        sInstr  = bus.if_instr;
        sPc4    = bus.if_pc_plus4;
        sAccept = expReq && bus.imem_ack;

        deliver = 0;
        if (bus.imem_rvalid) begin
            r = memQ.pop_front();
            deliver = !bus.redirect && (r.epoch == epoch);
        end
        if (bus.redirect) begin
            bufQ.delete();
            epoch++;
            fetchPc = bus.redirect_pc;
        end else begin
            if (pop) bufQ.delete(0);
            if (deliver) bufQ.push_back(r.addr);
            if (sAccept) begin
                memQ.push_back('{fetchPc, epoch, cyc + 1 + int'($urandom_range(unsigned'(maxLat - 1)))});
                fetchPc = fetchPc + 32'd4;
            end
        end
        cyc++;
    endtask

    task automatic waitValid(input string name);
        int n = 0;
        do begin
            stepCycle();
            n++;
        end while (!sValid && n < 40);
        if (!sValid) checkOutput({name, "_timeout"}, 32'(sValid), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int nAcc;
        bus.imem_ack    = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.stall       = 1'b0;

        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            checkOutput("rst_imem_req", 32'(bus.imem_req), 32'd0);
            checkOutput("rst_if_valid", 32'(bus.if_valid), 32'd0);
            checkOutput("rst_if_instr", bus.if_instr, NOP_INSTR);
            checkOutput("rst_if_pc_plus4", bus.if_pc_plus4, 32'h0);
        end

        // Streaming from reset with a one-cycle memory.
        ackPct = 100; rvPct = 100; maxLat = 1;
        for (int k = 0; k < 4; k++) begin
            stepCycle();
            case (k)
                0: begin
                    checkOutput("first_addr", sAddr, 32'h0);
                    checkOutput("first_req", 32'(sReq), 32'd1);
                    checkOutput("k0_valid", 32'(sValid), 32'd0);
                end
                1: checkOutput("second_addr", sAddr, 32'h4);
                2: begin
                    checkOutput("k2_valid", 32'(sValid), 32'd1);
                    checkOutput("k2_pc4", sPc4, 32'h4);
                    checkOutput("k2_instr", sInstr, memWord(32'h0));
                end
                default: begin
                    checkOutput("k3_pc4", sPc4, 32'h8);
                    checkOutput("k3_addr", sAddr, 32'hC);
                end
            endcase
        end
        repeat (3) stepCycle();

        // Stall held five cycles.
        forceStall = 1; nAcc = 0;
        for (int i = 0; i < 5; i++) begin
            stepCycle();
            nAcc += int'(sAccept);
            if (i == 4) checkOutput("stall_req_low", 32'(sReq), 32'd0);
        end
        forceStall = 0;
        checkOutput("stall_accepts_le_depth", 32'(nAcc <= DEPTH), 32'd1);
        repeat (4) stepCycle();

        // Redirect to 0x100 with two fetches in flight.
        rvPct = 0;
        for (int i = 0; i < 20 && memQ.size() != 2; i++) stepCycle();
        checkOutput("two_outstanding", 32'(memQ.size()), 32'd2);
        redirTarget = 32'h100; forceRedir = 1;
        stepCycle();
        rvPct = 100;
        waitValid("redir100");
        checkOutput("redir100_pc4", sPc4, 32'h104);
        checkOutput("redir100_instr", sInstr, memWord(32'h100));

        // Redirect coinciding with an rvalid while stalled.
        repeat (4) stepCycle();
        forceStall = 1; redirTarget = 32'h200; forceRedir = 1;
        stepCycle();
        stepCycle();
        checkOutput("after_redirect_valid", 32'(sValid), 32'd0);
        stepCycle();
        forceStall = 0;
        waitValid("redir200");
        checkOutput("redir200_pc4", sPc4, 32'h204);
        checkOutput("redir200_instr", sInstr, memWord(32'h200));

        // Memory ack held off for three cycles.
        repeat (2) stepCycle();
        redirTarget = 32'h300; forceRedir = 1;
        stepCycle();
        ackHoldOff = 3;
        for (int i = 0; i < 3; i++) begin
            stepCycle();
            checkOutput("held_req", 32'(sReq), 32'd1);
            checkOutput("held_addr", sAddr, 32'h300);
        end
        stepCycle();
        checkOutput("acked_addr", sAddr, 32'h300);
        stepCycle();
        checkOutput("after_ack_addr", sAddr, 32'h304);

        // PC wrap at the top of the address space.
        repeat (3) stepCycle();
        redirTarget = 32'hFFFF_FFFC; forceRedir = 1;
        stepCycle();
        stepCycle();
        checkOutput("wrap_addr_top", sAddr, 32'hFFFF_FFFC);
        stepCycle();
        checkOutput("wrap_addr_zero", sAddr, 32'h0);
        waitValid("wrap");
        checkOutput("wrap_pc4", sPc4, 32'h0);
        checkOutput("wrap_instr", sInstr, memWord(32'hFFFF_FFFC));

        // Randomized traffic.
        ackPct = 70; rvPct = 60; stallPct = 25; redirPct = 4; maxLat = 4;
        repeat (3000) stepCycle();

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
